tgs_sched: RTL and testbench

Traffic-generation scheduler sitting directly downstream of the per-queue token-bucket request stages and upstream of the packet generator. Collects one request bit per queue, masks it with the gate-control open state, and picks one queue by round-robin. It returns a one-cycle `selected` pulse to the winning token bucket so that bucket consumes tokens, and hands the queue ID to the generator. It then waits for generation to finish and inserts a settle gap so the bucket's remaining-token update has propagated before the next arbitration.

---
 rtl/tgs_sched_pkg.sv | 23 ++
 rtl/tgs_sched_rr_pick.sv | 39 +++
 rtl/tgs_sched.sv | 141 ++++++++++++++
 tb/tb_tgs_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tgs_sched_pkg.sv
// tgs_sched_pkg: shared definitions for the traffic-generation scheduler.
//   - tsm_state_e : scheduler state encoding (IDLE/GRANT/WAIT/HOLD, 2-bit)
//   - default queue count, queue-ID width, settle length and done timeout
package tgs_sched_pkg;

   typedef enum logic [1:0] {
      TSM_IDLE  = 2'd0,
      TSM_GRANT = 2'd1,
      TSM_WAIT  = 2'd2,
      TSM_HOLD  = 2'd3
   } tsm_state_e;

   localparam int unsigned QUEUE_NUM_DEF    = 8;
   localparam int unsigned QID_W_DEF        = $clog2(QUEUE_NUM_DEF);
   localparam int unsigned HOLD_CYC_DEF     = 3;
   localparam logic [15:0] DONE_TIMEOUT_DEF = 16'd4096;

   // Queue-ID width for a given queue count.
   function automatic int unsigned qid_width(input int unsigned queue_num);
      return $clog2(queue_num);
   endfunction

endpackage

// File: rtl/tgs_sched_rr_pick.sv
// rr_pick: combinational round-robin pick.
//   req_i   : request vector, one bit per queue
//   last_i  : index granted last time; the scan starts at last_i + 1
//   found_o : at least one request is set
//   idx_o   : first requesting index at or after last_i + 1, wrapping
module rr_pick #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 3
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] last_i,
   output logic         found_o,
   output logic [W-1:0] idx_o
);

   localparam logic [W+1:0] NumQ = (W + 2)'(N);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [W:0]     start;
   logic [W:0]     off;
   logic [W+1:0]   sum;

   always_comb begin
      start   = {1'b0, last_i} + (W + 1)'(1);
      // Two copies back to back so a plain right shift acts as a rotate.
      dbl     = {req_i, req_i} >> start;
      rot     = dbl[N-1:0];
      found_o = |rot;
      off     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) off = i[W:0];
      end
      sum = {1'b0, start} + {1'b0, off};
      if (sum >= NumQ) sum = sum - NumQ;
      idx_o = sum[W-1:0];
   end

endmodule

// File: rtl/tgs_sched.sv
// tgs_sched: round-robin scheduler between token-bucket request stages and the
// packet generator.
//   clk, rst_n           : clock, synchronous active-low reset
//   test_stop            : blocks new grants while high
//   in_tsm_req           : per-queue generation request
//   in_gcm_gate_open     : per-queue gate state (1 = open)
//   in_tsm_gen_done      : generator finished the frame (pulse)
//   out_tsm_selected     : one-hot grant pulse to the winning bucket
//   out_tsm_gen_valid    : grant pulse to the generator
//   out_tsm_gen_qid      : granted queue ID, stable until back in IDLE
//   out_tsm_busy         : transaction in progress
//   out_tsm_timeout      : pulse when waiting for done was aborted
//   out_tsm_grant_cnt    : grants since reset
module tgs_sched
   import tgs_sched_pkg::*;
#(
   parameter string       PLATFORM     = "xilinx",
   parameter int unsigned QUEUE_NUM    = QUEUE_NUM_DEF,
   parameter int unsigned QID_W        = QID_W_DEF,
   parameter int unsigned HOLD_CYC     = HOLD_CYC_DEF,
   parameter logic [15:0] DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 test_stop,
   input  logic [QUEUE_NUM-1:0] in_tsm_req,
   input  logic [QUEUE_NUM-1:0] in_gcm_gate_open,
   input  logic                 in_tsm_gen_done,
   output logic [QUEUE_NUM-1:0] out_tsm_selected,
   output logic                 out_tsm_gen_valid,
   output logic [QID_W-1:0]     out_tsm_gen_qid,
   output logic                 out_tsm_busy,
   output logic                 out_tsm_timeout,
   output logic [31:0]          out_tsm_grant_cnt
);

   localparam logic [15:0] HoldLast = 16'(HOLD_CYC - 1);
   localparam logic [15:0] WaitLast = DONE_TIMEOUT - 16'd1;

   tsm_state_e      state_q, state_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [QID_W-1:0] qid_q, qid_d;
   logic [QID_W-1:0] last_q, last_d;
   logic            timeout_q, timeout_d;
   logic [31:0]     grant_cnt_q, grant_cnt_d;

   logic [QUEUE_NUM-1:0] eligible;
   logic                 pick_found;
   logic [QID_W-1:0]     pick_idx;

   assign eligible = in_tsm_req & in_gcm_gate_open;

   rr_pick #(
      .N (QUEUE_NUM),
      .W (QID_W)
   ) u_rr_pick (
      .req_i   (eligible),
      .last_i  (last_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      qid_d       = qid_q;
      last_d      = last_q;
      timeout_d   = 1'b0;
      grant_cnt_d = grant_cnt_q;
      unique case (state_q)
         TSM_IDLE: begin
            if (!test_stop && pick_found) begin
               qid_d   = pick_idx;
               last_d  = pick_idx;
               state_d = TSM_GRANT;
            end
         end
         TSM_GRANT: begin
            grant_cnt_d = grant_cnt_q + 32'd1;
            cnt_d       = '0;
            state_d     = TSM_WAIT;
         end
         TSM_WAIT: begin
            // Done has priority over the timeout limit in the same cycle.
            if (in_tsm_gen_done) begin
               cnt_d   = '0;
               state_d = TSM_HOLD;
            end else if (cnt_q == WaitLast) begin
               cnt_d     = '0;
               timeout_d = 1'b1;
               state_d   = TSM_HOLD;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         TSM_HOLD: begin
            // Settle gap so the bucket's token update lands before re-arbitration.
            if (cnt_q == HoldLast) begin
               state_d = TSM_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = TSM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= TSM_IDLE;
         cnt_q       <= '0;
         qid_q       <= '0;
         last_q      <= QID_W'(QUEUE_NUM - 1);
         timeout_q   <= 1'b0;
         grant_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         qid_q       <= qid_d;
         last_q      <= last_d;
         timeout_q   <= timeout_d;
         grant_cnt_q <= grant_cnt_d;
      end
   end

   always_comb begin
      out_tsm_selected = '0;
      if (state_q == TSM_GRANT) begin
         for (int i = 0; i < QUEUE_NUM; i++) begin
            out_tsm_selected[i] = (qid_q == i[QID_W-1:0]);
         end
      end
   end

   assign out_tsm_gen_valid = (state_q == TSM_GRANT);
   assign out_tsm_gen_qid   = qid_q;
   assign out_tsm_busy      = (state_q != TSM_IDLE);
   assign out_tsm_timeout   = timeout_q;
   assign out_tsm_grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_tgs_sched.sv
// tb_tgs_sched: randomized and directed stimulus for tgs_sched, checked every
// cycle against a transaction-age reference model.
module tb_tgs_sched;

   localparam int Q    = 8;
   localparam int HOLD = 3;
   localparam int DT   = 40;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         test_stop;
   logic [Q-1:0] in_req;
   logic [Q-1:0] in_gate;
   logic         in_done;
   logic [Q-1:0] out_sel;
   logic         out_valid;
   logic [2:0]   out_qid;
   logic         out_busy;
   logic         out_timeout;
   logic [31:0]  out_gcnt;

   always #5 clk = ~clk;

   tgs_sched #(
      .PLATFORM     ("xilinx"),
      .QUEUE_NUM    (Q),
      .QID_W        (3),
      .HOLD_CYC     (HOLD),
      .DONE_TIMEOUT (16'(DT))
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .test_stop         (test_stop),
      .in_tsm_req        (in_req),
      .in_gcm_gate_open  (in_gate),
      .in_tsm_gen_done   (in_done),
      .out_tsm_selected  (out_sel),
      .out_tsm_gen_valid (out_valid),
      .out_tsm_gen_qid   (out_qid),
      .out_tsm_busy      (out_busy),
      .out_tsm_timeout   (out_timeout),
      .out_tsm_grant_cnt (out_gcnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: a transaction is described by its age (cycles since the
   // grant cycle) and the age at which waiting for done ended.
   bit          m_busy;
   int          m_age;
   int          m_end;
   bit          m_to;
   int          m_ptr;
   int          m_qid;
   logic [31:0] m_cnt;
   int          grant_log[$];

   function automatic int rr_ref(input logic [Q-1:0] elig, input int ptr);
      for (int k = 1; k <= Q; k++) begin
         int j;
         j = (ptr + k) % Q;
         if (elig[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0;
      m_age  = 0;
      m_end  = -1;
      m_to   = 0;
      m_ptr  = Q - 1;
      m_qid  = 0;
      m_cnt  = '0;
   endtask

   task automatic model_step(input logic [Q-1:0] elig, input logic done, input logic stop,
                             input logic rstn);
      int p;
      if (!rstn) begin
         model_reset();
      end else if (!m_busy) begin
         p = rr_ref(elig, m_ptr);
         if (!stop && p >= 0) begin
            m_qid  = p;
            m_ptr  = p;
            m_busy = 1;
            m_age  = 0;
            m_end  = -1;
            m_to   = 0;
         end
      end else begin
         if (m_age == 0) m_cnt = m_cnt + 32'd1;
         if (m_end < 0 && m_age >= 1) begin
            if (done) m_end = m_age;
            else if (m_age == DT) begin
               m_end = m_age;
               m_to  = 1;
            end
         end
         if (m_end >= 0 && m_age == m_end + HOLD) m_busy = 0;
         m_age++;
      end
   endtask

   // Called at a falling edge: check this cycle's outputs, drive the inputs
   // for the next rising edge, advance the model, wait one cycle.
   task automatic tick(input logic [Q-1:0] req, input logic [Q-1:0] gate, input logic done,
                       input logic stop, input logic rstn);
      logic [Q-1:0] e_sel;
      e_sel = '0;
      if (m_busy && m_age == 0) e_sel[m_qid] = 1'b1;
      check_eq("selected", 32'(out_sel), 32'(e_sel));
      check_eq("gen_valid", 32'(out_valid), 32'(m_busy && m_age == 0));
      check_eq("qid", 32'(out_qid), 32'(m_qid));
      check_eq("busy", 32'(out_busy), 32'(m_busy));
      check_eq("timeout", 32'(out_timeout), 32'(m_busy && m_to && m_age == m_end + 1));
      check_eq("grant_cnt", out_gcnt, m_cnt);
      if (out_valid === 1'b1) grant_log.push_back(int'(out_qid));
      in_req    = req;
      in_gate   = gate;
      in_done   = done;
      test_stop = stop;
      rst_n     = rstn;
      model_step(req & gate, done, stop, rstn);
      @(negedge clk);
   endtask

   // Run n cycles; done is returned when the transaction reaches done_age
   // (0 = never).
   task automatic run(input logic [Q-1:0] req, input logic [Q-1:0] gate, input logic stop,
                      input int done_age, input int n);
      for (int c = 0; c < n; c++) begin
         tick(req, gate, (done_age != 0) && m_busy && (m_age == done_age), stop, 1'b1);
      end
   endtask

   int exp_order[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

   initial begin
      logic [Q-1:0] r_req, r_gate;
      logic         r_stop;
      rst_n     = 1'b0;
      test_stop = 1'b0;
      in_req    = '0;
      in_gate   = '0;
      in_done   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();

      // Single request on queue 0, done after 5 wait cycles.
      run(8'h01, 8'hFF, 1'b0, 6, 1);
      run(8'h00, 8'hFF, 1'b0, 6, 15);
      check_eq("single_grant_cnt", out_gcnt, 32'd1);
      check_eq("single_idle", 32'(out_busy), 32'd0);

      // All requesting after reset: strict order 0..7 then 0.
      tick('0, '0, 1'b0, 1'b0, 1'b0);
      grant_log.delete();
      run(8'hFF, 8'hFF, 1'b0, 2, 9 * 7);
      check_eq("rr_count", 32'(grant_log.size()), 32'd9);
      for (int i = 0; i < 9 && i < grant_log.size(); i++) begin
         check_eq("rr_order", 32'(grant_log[i]), 32'(exp_order[i]));
      end

      // Gate masking, then queue 2 opens and wraps in.
      run(8'h0C, 8'h08, 1'b0, 2, 20);
      run(8'h0C, 8'h0C, 1'b0, 2, 20);

      // Done never returned, then done exactly at the timeout boundary.
      run(8'h01, 8'hFF, 1'b0, 0, DT + 12);
      run(8'h01, 8'hFF, 1'b0, DT, DT + 12);

      // test_stop while a transaction is in flight.
      run(8'hFF, 8'hFF, 1'b0, 3, 3);
      run(8'hFF, 8'hFF, 1'b1, 3, 30);
      run(8'hFF, 8'hFF, 1'b0, 3, 10);

      // Reset during WAIT_DONE, then lowest eligible queue wins.
      run(8'h00, 8'hFF, 1'b0, 0, 10);
      run(8'h10, 8'hFF, 1'b0, 0, 4);
      tick(8'h10, 8'hFF, 1'b0, 1'b0, 1'b0);
      run(8'h14, 8'hFF, 1'b0, 2, 12);

      // Random traffic.
      r_stop = 1'b0;
      for (int c = 0; c < 2500; c++) begin
         r_req  = 8'($urandom);
         r_gate = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         if ($urandom_range(0, 19) == 0) r_stop = ~r_stop;
         tick(r_req, r_gate, $urandom_range(0, 15) == 0, r_stop,
              $urandom_range(0, 299) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
